// File: rtl/ring_thread_injector_if.sv
// Token channel from the thread injector into station 0 of the engine ring.
//
// Valid/ready contract: a token moves when valid && ready are both 1 at a rising
// clock edge. Once the master raises valid it holds data and latency stable and
// keeps valid high until that transfer happens; ready may toggle freely.
interface ring_thread_injector_if #(
  parameter int PC_WIDTH            = 8,
  parameter int CC_ID_BITS          = 2,
  parameter int LATENCY_COUNT_WIDTH = 8
);
  logic [PC_WIDTH+CC_ID_BITS-1:0] data;
  logic [LATENCY_COUNT_WIDTH-1:0] latency;
  logic                           valid;
  logic                           ready;

  modport master (output data, output latency, output valid, input ready);
  modport slave  (input data, input latency, input valid, output ready);
endinterface

// File: rtl/ring_thread_injector.sv
// Transmitter end of the engine-ring channel. On each new character it emits one
// start token {cc_id, START_PC} per enabled character-context slot (lowest slot
// first, at most one per cycle), waits for the ring to stay idle for DRAIN_CYCLES
// consecutive cycles, then pulses char_done_o so the window controller can advance.
module ring_thread_injector #(
  parameter int PC_WIDTH            = 8,
  parameter int CC_ID_BITS          = 2,
  parameter int LATENCY_COUNT_WIDTH = 8,
  parameter int START_PC            = 0,
  parameter int DRAIN_CYCLES        = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          new_char_i,
  input  logic [(1<<CC_ID_BITS)-1:0]    cur_window_enable_i,
  input  logic                          ring_running_i,
  input  logic [(1<<CC_ID_BITS)-1:0]    elaborating_chars_i,
  ring_thread_injector_if.master        out_if,
  output logic                          busy_o,
  output logic                          char_done_o,
  output logic                          overrun_o,
  output logic [1:0]                    state_o
);

  localparam int NUM_SLOTS = 1 << CC_ID_BITS;
  localparam int DW        = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [PC_WIDTH-1:0] START_PC_L   = PC_WIDTH'(START_PC);
  localparam logic [DW-1:0]       DRAIN_LAST_M1 = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_INJECT = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            state_q,   state_d;
  logic [NUM_SLOTS-1:0]  pending_q, pending_d;
  logic [DW-1:0]         drain_q,   drain_d;
  logic                  overrun_q, overrun_d;
  logic [CC_ID_BITS-1:0] head_idx;
  logic                  ring_idle;

  assign ring_idle = !ring_running_i && (elaborating_chars_i == '0);

  // Pick the lowest-index pending slot; it is the token currently offered.
  always_comb begin
    head_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pending_q[i]) head_idx = CC_ID_BITS'(i);
    end
  end

  // Next-state logic for the inject / drain / done sequence.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    drain_d   = drain_q;
    overrun_d = overrun_q | (new_char_i && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        drain_d = '0;
        if (new_char_i) begin
          if (cur_window_enable_i != '0) begin
            pending_d = cur_window_enable_i;
            state_d   = S_INJECT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_INJECT: begin
        if (out_if.ready) begin
          // Clearing the lowest set bit retires exactly the token just accepted.
          pending_d = pending_q & (pending_q - NUM_SLOTS'(1));
          if ((pending_q & (pending_q - NUM_SLOTS'(1))) == '0) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ring_idle) begin
          if (drain_q == DRAIN_LAST_M1) begin
            drain_d = '0;
            state_d = S_DONE;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end else begin
          drain_d = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        pending_d = '0;
        drain_d   = '0;
      end
    endcase
  end

  // State registers; reset drops any offered token and all pending slots at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      drain_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      drain_q   <= drain_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decode straight from registered state, so valid/data are glitch-free
  // and stay stable while a token waits for ready.
  always_comb begin
    out_if.valid   = (state_q == S_INJECT);
    out_if.data    = (state_q == S_INJECT) ? {head_idx, START_PC_L} : '0;
    out_if.latency = '0;
    busy_o         = (state_q != S_IDLE);
    char_done_o    = (state_q == S_DONE);
    overrun_o      = overrun_q;
    state_o        = state_q;
  end

endmodule

// File: tb/tb_ring_thread_injector.sv
// Bench for ring_thread_injector: directed scenarios followed by randomized
// characters, every cycle compared against a token-list / idle-history model.
module tb_ring_thread_injector;

  localparam int PC_W  = 8;
  localparam int CC_B  = 2;
  localparam int LAT_W = 8;
  localparam int SPC   = 8'h3C;
  localparam int DRAIN = 2;

  logic       clk;
  logic       rst;
  logic       new_char;
  logic [3:0] win_en;
  logic       ring_running;
  logic [3:0] elab;
  logic       busy;
  logic       char_done;
  logic       overrun;
  logic [1:0] state_dbg;

  ring_thread_injector_if #(.PC_WIDTH(PC_W), .CC_ID_BITS(CC_B), .LATENCY_COUNT_WIDTH(LAT_W)) out_if ();

  ring_thread_injector #(
    .PC_WIDTH(PC_W), .CC_ID_BITS(CC_B), .LATENCY_COUNT_WIDTH(LAT_W),
    .START_PC(SPC), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .new_char_i          (new_char),
    .cur_window_enable_i (win_en),
    .ring_running_i      (ring_running),
    .elaborating_chars_i (elab),
    .out_if              (out_if),
    .busy_o              (busy),
    .char_done_o         (char_done),
    .overrun_o           (overrun),
    .state_o             (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  bit exp_overrun = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One character: new_char at relative cycle 0, then cycle-by-cycle comparison.
  // Model: the expected tokens are the set bits of en in ascending order; char_done
  // falls on the first cycle preceded by DRAIN idle-ring cycles that all lie after
  // the cycle of the last accepted token (or on cycle 1 when en is empty).
  task automatic run_char(input logic [3:0] en, input int ready_low, input bit rand_ready,
                          input int busy_len, input bit rand_ring, input int extra_at);
    logic [1:0] tok_q[$];
    bit  idle_h[0:255];
    int  k, last_c, done_c;
    bit  finished, exp_valid, exp_busy, exp_done, rdy, b;
    logic [31:0] exp_data;
    tok_q = {};
    for (int i = 0; i < 4; i++) if (en[i]) tok_q.push_back(2'(i));
    k = tok_q.size();
    last_c = -1;
    done_c = -1;
    finished = 1'b0;
    for (int c = 0; c < 200; c++) begin
      exp_valid = (c >= 1) && (tok_q.size() > 0);
      exp_done  = 1'b0;
      if (done_c < 0 && c >= 1) begin
        if (k == 0) exp_done = (c == 1);
        else if (last_c >= 0 && (c - DRAIN) >= (last_c + 1)) begin
          exp_done = 1'b1;
          for (int j = c - DRAIN; j < c; j++) if (!idle_h[j]) exp_done = 1'b0;
        end
      end
      exp_busy = (c >= 1) && (done_c < 0);
      check("valid", out_if.valid, exp_valid);
      if (exp_valid) begin
        exp_data = {22'd0, tok_q[0], 8'(SPC)};
        check("data", out_if.data, exp_data);
      end
      check("latency", out_if.latency, 0);
      check("busy", busy, exp_busy);
      check("char_done", char_done, exp_done);
      check("overrun", overrun, exp_overrun);
      if (exp_done) done_c = c;
      if (done_c >= 0 && c == done_c + 1) begin
        finished = 1'b1;
        break;
      end
      // Drive inputs for this cycle.
      new_char = (c == 0) || (c == extra_at);
      win_en   = (c == 0) ? en : 4'($urandom_range(0, 15));
      if (c >= 1 && c == extra_at) exp_overrun = 1'b1;
      if (rand_ready) rdy = ($urandom_range(0, 2) != 0) || (c > 40);
      else            rdy = !(c >= 1 && c <= ready_low);
      out_if.ready = rdy;
      b = (c >= 1 && c <= busy_len) || (rand_ring && c < 60 && $urandom_range(0, 2) == 0);
      if (b) begin
        ring_running = 1'($urandom_range(0, 1));
        elab = ring_running ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
      end else begin
        ring_running = 1'b0;
        elab = 4'd0;
      end
      idle_h[c] = !b;
      if (exp_valid && rdy) begin
        void'(tok_q.pop_front());
        if (tok_q.size() == 0) last_c = c;
      end
      @(negedge clk);
    end
    new_char = 1'b0;
    check("char_completed_in_budget", finished, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    new_char = 1'b0;
    win_en = 4'd0;
    ring_running = 1'b0;
    elab = 4'd0;
    out_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_valid", out_if.valid, 0);
    check("rst_data", out_if.data, 0);
    check("rst_latency", out_if.latency, 0);
    check("rst_busy", busy, 0);
    check("rst_char_done", char_done, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    @(negedge clk);

    // Three slots, ready always high, idle ring: done at t+6.
    run_char(4'b1011, 0, 1'b0, 0, 1'b0, -1);
    // Single slot 2 with ready low for 5 cycles: token held stable.
    run_char(4'b0100, 5, 1'b0, 0, 1'b0, -1);
    // Empty enable: no tokens, done at t+1.
    run_char(4'b0000, 0, 1'b0, 0, 1'b0, -1);
    // Ring busy long after injection delays char_done.
    run_char(4'b0001, 0, 1'b0, 12, 1'b0, -1);
    // Full window, second new_char during WAIT is ignored and sets overrun.
    run_char(4'b1111, 0, 1'b0, 8, 1'b0, 6);
    // Second new_char landing during INJECT while stalled.
    run_char(4'b0110, 3, 1'b0, 0, 1'b0, 2);

    // Randomized characters.
    for (int n = 0; n < 40; n++) begin
      run_char(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
               1'($urandom_range(0, 1)), $urandom_range(0, 12), 1'b1,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : -1);
    end

    // Asynchronous reset while a token is offered.
    new_char = 1'b1;
    win_en = 4'b1111;
    out_if.ready = 1'b0;
    @(negedge clk);
    new_char = 1'b0;
    check("pre_reset_valid", out_if.valid, 1);
    #2 rst = 1'b0;
    #1;
    exp_overrun = 1'b0;
    check("async_rst_valid", out_if.valid, 0);
    check("async_rst_data", out_if.data, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    out_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", out_if.valid, 0);
      check("post_rst_busy", busy, 0);
    end
    // Normal operation after reset.
    run_char(4'b1010, 0, 1'b0, 3, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
